// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SRAM memory-stage controller: widths and FSM encoding.
package mem_ctrl_pkg;

    localparam int ADDR_PAD_W = 2;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = ADDR_PAD_W + DATA_W;
    localparam int REG_W      = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_SETUP  = 3'd1,
        RD_SAMPLE = 3'd2,
        WR_SETUP  = 3'd3,
        WR_PULSE  = 3'd4,
        WR_HOLD   = 3'd5
    } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Memory pipeline stage: runs asynchronous-SRAM read/write cycles, stalls the
// upstream pipeline during an access and feeds results to the MEM/WB register.
//
// Handshake: a request (memread_in/memwrite_in) is taken only in IDLE. The
// upstream stage must hold its inputs while stall is high; the cycle in which
// stall drops is the last cycle those inputs are consumed.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              memread_in,
    input  logic              memwrite_in,
    input  logic              controlwb_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [REG_W-1:0]  wreg_in,
    output logic              stall,
    output logic              controlwb_out,
    output logic [REG_W-1:0]  wreg_out,
    output logic [DATA_W-1:0] wbdata_out,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              ram_data_oe,
    output logic              ram_en_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output state_t            fsm_state
);

    state_t             state;
    state_t             state_next;
    logic [REG_W-1:0]   wreg_q;
    logic               controlwb_q;
    logic               accept;

    assign accept    = (state == IDLE) && (memread_in || memwrite_in);
    assign fsm_state = state;

    // State register; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: writes take priority over reads when both are requested.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (memwrite_in)     state_next = WR_SETUP;
                else if (memread_in) state_next = RD_SETUP;
            end
            RD_SETUP:  state_next = RD_SAMPLE;
            RD_SAMPLE: state_next = IDLE;
            WR_SETUP:  state_next = WR_PULSE;
            WR_PULSE:  state_next = WR_HOLD;
            WR_HOLD:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Strobes and stall decoded from state; we_n pulses only in the middle write cycle.
    always_comb begin
        stall       = 1'b0;
        ram_en_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_data_oe = 1'b0;
        case (state)
            IDLE: stall = memread_in || memwrite_in;
            RD_SETUP: begin
                stall    = 1'b1;
                ram_en_n = 1'b0;
                ram_oe_n = 1'b0;
            end
            RD_SAMPLE: begin
                ram_en_n = 1'b0;
                ram_oe_n = 1'b0;
            end
            WR_SETUP: begin
                stall       = 1'b1;
                ram_en_n    = 1'b0;
                ram_data_oe = 1'b1;
            end
            WR_PULSE: begin
                stall       = 1'b1;
                ram_en_n    = 1'b0;
                ram_we_n    = 1'b0;
                ram_data_oe = 1'b1;
            end
            WR_HOLD: begin
                ram_en_n    = 1'b0;
                ram_data_oe = 1'b1;
            end
            default: stall = 1'b0;
        endcase
    end

    // Request latch: address/data stay on the SRAM pins until the next accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr    <= '0;
            ram_data_o  <= '0;
            wreg_q      <= '0;
            controlwb_q <= 1'b0;
        end else if (accept) begin
            ram_addr    <= {{ADDR_PAD_W{1'b0}}, alu_in};
            ram_data_o  <= wdata_in;
            wreg_q      <= wreg_in;
            controlwb_q <= controlwb_in;
        end
    end

    // MEM/WB output register: bubble while stalled, otherwise the finished result.
    always_ff @(posedge clk) begin
        if (rst) begin
            controlwb_out <= 1'b0;
            wreg_out      <= '0;
            wbdata_out    <= '0;
        end else if (stall) begin
            controlwb_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    controlwb_out <= controlwb_in;
                    wreg_out      <= wreg_in;
                    wbdata_out    <= alu_in;
                end
                RD_SAMPLE: begin
                    controlwb_out <= controlwb_q;
                    wreg_out      <= wreg_q;
                    wbdata_out    <= ram_data_i;
                end
                default: controlwb_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small behavioural SRAM attached.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic              clk;
    logic              rst;
    logic              memread_in;
    logic              memwrite_in;
    logic              controlwb_in;
    logic [15:0]       alu_in;
    logic [15:0]       wdata_in;
    logic [3:0]        wreg_in;
    logic              stall;
    logic              controlwb_out;
    logic [3:0]        wreg_out;
    logic [15:0]       wbdata_out;
    logic [17:0]       ram_addr;
    logic [15:0]       ram_data_o;
    logic [15:0]       ram_data_i;
    logic              ram_data_oe;
    logic              ram_en_n;
    logic              ram_oe_n;
    logic              ram_we_n;
    state_t            fsm_state;

    int checks;
    int failures;

    logic [15:0] sram [0:255];

    int          n_stall, n_oe, n_we, n_de, we_pos, overlap;
    logic [17:0] addr_seen;
    state_t      state_seen;
    logic        cwb_bubble;

    mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .memread_in    (memread_in),
        .memwrite_in   (memwrite_in),
        .controlwb_in  (controlwb_in),
        .alu_in        (alu_in),
        .wdata_in      (wdata_in),
        .wreg_in       (wreg_in),
        .stall         (stall),
        .controlwb_out (controlwb_out),
        .wreg_out      (wreg_out),
        .wbdata_out    (wbdata_out),
        .ram_addr      (ram_addr),
        .ram_data_o    (ram_data_o),
        .ram_data_i    (ram_data_i),
        .ram_data_oe   (ram_data_oe),
        .ram_en_n      (ram_en_n),
        .ram_oe_n      (ram_oe_n),
        .ram_we_n      (ram_we_n),
        .fsm_state     (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: combinational read while oe_n low, write at edge while we_n low
    assign ram_data_i = (!ram_oe_n && !ram_en_n) ? sram[ram_addr[7:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!ram_we_n && !ram_en_n && ram_data_oe) sram[ram_addr[7:0]] <= ram_data_o;
    end

    task automatic set_idle_inputs();
        memread_in   = 1'b0;
        memwrite_in  = 1'b0;
        controlwb_in = 1'b0;
        alu_in       = 16'h0000;
        wdata_in     = 16'h0000;
        wreg_in      = 4'h0;
    endtask

    // Present one operation and hold it until stall drops, counting strobe cycles.
    task automatic run_op(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [3:0] r, input logic c);
        int  cyc;
        bit  done;
        memread_in   = rd;
        memwrite_in  = wr;
        alu_in       = a;
        wdata_in     = d;
        wreg_in      = r;
        controlwb_in = c;
        n_stall = 0; n_oe = 0; n_we = 0; n_de = 0; we_pos = -1; overlap = 0;
        addr_seen = '0; state_seen = IDLE; cwb_bubble = 1'b0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 12) begin
            #1;
            if (stall) n_stall++;
            if (!ram_oe_n) n_oe++;
            if (!ram_we_n) begin n_we++; we_pos = cyc; end
            if (ram_data_oe) n_de++;
            if (!ram_oe_n && (!ram_we_n || ram_data_oe)) overlap++;
            if (cyc == 1) begin
                addr_seen  = ram_addr;
                state_seen = fsm_state;
                cwb_bubble = controlwb_out;
            end
            if (!stall) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL op_timeout stall still high after %0d cycles", cyc);
        end
        set_idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (fsm_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE); end
        checks++;
        if ({controlwb_out, wreg_out, wbdata_out} !== 21'h0) begin
            failures++; $display("FAIL reset_outputs got=%b/%h/%h exp=0/0/0", controlwb_out, wreg_out, wbdata_out);
        end
        checks++;
        if (ram_addr !== 18'h0 || ram_data_o !== 16'h0) begin
            failures++; $display("FAIL reset_ram_bus got addr=%h data=%h exp=0/0", ram_addr, ram_data_o);
        end
        checks++;
        if ({ram_en_n, ram_oe_n, ram_we_n, ram_data_oe, stall} !== 5'b11100) begin
            failures++; $display("FAIL reset_strobes got en/oe/we/doe/stall=%b exp=11100", {ram_en_n, ram_oe_n, ram_we_n, ram_data_oe, stall});
        end
    endtask

    task automatic test_passthrough();
        run_op(1'b0, 1'b0, 16'h0005, 16'h0000, 4'd7, 1'b1);
        checks++;
        if (n_stall !== 0) begin failures++; $display("FAIL pass_stall got=%0d exp=0", n_stall); end
        checks++;
        if ({controlwb_out, wreg_out, wbdata_out} !== {1'b1, 4'd7, 16'h0005}) begin
            failures++; $display("FAIL pass_result got=%b/%h/%h exp=1/7/0005", controlwb_out, wreg_out, wbdata_out);
        end
        checks++;
        if (ram_en_n !== 1'b1) begin failures++; $display("FAIL pass_en got=%b exp=1", ram_en_n); end
    endtask

    task automatic check_load(input string tag, input logic [17:0] exp_addr,
                              input logic [15:0] exp_data, input logic [3:0] exp_reg);
        checks++;
        if (n_stall !== 2 || n_oe !== 2 || n_we !== 0 || n_de !== 0) begin
            failures++;
            $display("FAIL %s_counts got stall=%0d oe=%0d we=%0d doe=%0d exp 2/2/0/0", tag, n_stall, n_oe, n_we, n_de);
        end
        checks++;
        if (addr_seen !== exp_addr) begin failures++; $display("FAIL %s_addr got=%h exp=%h", tag, addr_seen, exp_addr); end
        checks++;
        if (state_seen !== RD_SETUP) begin failures++; $display("FAIL %s_first_state got=%0d exp=%0d", tag, state_seen, RD_SETUP); end
        checks++;
        if (cwb_bubble !== 1'b0) begin failures++; $display("FAIL %s_bubble got=%b exp=0", tag, cwb_bubble); end
        checks++;
        if ({controlwb_out, wreg_out, wbdata_out} !== {1'b1, exp_reg, exp_data}) begin
            failures++; $display("FAIL %s_result got=%b/%h/%h exp=1/%h/%h", tag, controlwb_out, wreg_out, wbdata_out, exp_reg, exp_data);
        end
    endtask

    task automatic check_store(input string tag, input logic [17:0] exp_addr,
                               input logic [15:0] exp_data, input logic [15:0] old_wb);
        checks++;
        if (n_stall !== 3 || n_de !== 3 || n_we !== 1 || we_pos !== 2 || n_oe !== 0) begin
            failures++;
            $display("FAIL %s_counts got stall=%0d doe=%0d we=%0d we_pos=%0d oe=%0d exp 3/3/1/2/0", tag, n_stall, n_de, n_we, we_pos, n_oe);
        end
        checks++;
        if (addr_seen !== exp_addr || ram_data_o !== exp_data) begin
            failures++; $display("FAIL %s_bus got addr=%h data=%h exp=%h/%h", tag, addr_seen, ram_data_o, exp_addr, exp_data);
        end
        checks++;
        if (state_seen !== WR_SETUP) begin failures++; $display("FAIL %s_first_state got=%0d exp=%0d", tag, state_seen, WR_SETUP); end
        checks++;
        if (controlwb_out !== 1'b0 || wbdata_out !== old_wb) begin
            failures++; $display("FAIL %s_wb got cwb=%b wb=%h exp=0/%h", tag, controlwb_out, wbdata_out, old_wb);
        end
        checks++;
        if (sram[exp_addr[7:0]] !== exp_data) begin
            failures++; $display("FAIL %s_sram got=%h exp=%h", tag, sram[exp_addr[7:0]], exp_data);
        end
    endtask

    task automatic test_load();
        run_op(1'b1, 1'b0, 16'h0040, 16'h0000, 4'd3, 1'b1);
        check_load("load", 18'h00040, 16'h1234, 4'd3);
    endtask

    task automatic test_store();
        run_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 4'd5, 1'b1);
        check_store("store", 18'h00010, 16'hBEEF, 16'h1234);
    endtask

    task automatic test_simultaneous();
        run_op(1'b1, 1'b1, 16'h0020, 16'hCAFE, 4'd6, 1'b1);
        check_store("simul", 18'h00020, 16'hCAFE, 16'h1234);
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b0, 16'h0010, 16'h0000, 4'd9, 1'b1);
        check_load("b2b_load", 18'h00010, 16'hBEEF, 4'd9);
        checks++;
        if (overlap !== 0) begin failures++; $display("FAIL b2b_load_overlap got=%0d exp=0", overlap); end
        run_op(1'b0, 1'b1, 16'h0030, 16'h5555, 4'd1, 1'b1);
        check_store("b2b_store", 18'h00030, 16'h5555, 16'hBEEF);
        checks++;
        if (overlap !== 0) begin failures++; $display("FAIL b2b_store_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_reset_mid_write();
        memwrite_in  = 1'b1;
        alu_in       = 16'h0050;
        wdata_in     = 16'hDEAD;
        wreg_in      = 4'd4;
        controlwb_in = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        #1;
        checks++;
        if (fsm_state !== WR_PULSE || ram_we_n !== 1'b0) begin
            failures++; $display("FAIL rstw_reach got state=%0d we_n=%b exp=%0d/0", fsm_state, ram_we_n, WR_PULSE);
        end
        set_idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (fsm_state !== IDLE || ram_we_n !== 1'b1 || ram_data_oe !== 1'b0 || ram_en_n !== 1'b1) begin
            failures++; $display("FAIL rstw_after got state=%0d we_n=%b doe=%b en_n=%b exp=%0d/1/0/1", fsm_state, ram_we_n, ram_data_oe, ram_en_n, IDLE);
        end
        checks++;
        if (ram_addr !== 18'h0 || ram_data_o !== 16'h0 || controlwb_out !== 1'b0 || wbdata_out !== 16'h0) begin
            failures++; $display("FAIL rstw_regs got addr=%h data=%h cwb=%b wb=%h exp=0/0/0/0", ram_addr, ram_data_o, controlwb_out, wbdata_out);
        end
        // Dropped access: idle cycles with no strobes before the next load
        repeat (2) begin @(posedge clk); @(negedge clk); end
        #1;
        checks++;
        if (fsm_state !== IDLE || ram_en_n !== 1'b1) begin
            failures++; $display("FAIL rstw_dropped got state=%0d en_n=%b exp=%0d/1", fsm_state, ram_en_n, IDLE);
        end
        run_op(1'b1, 1'b0, 16'h0040, 16'h0000, 4'd2, 1'b1);
        check_load("rstw_load", 18'h00040, 16'h1234, 4'd2);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        sram[8'h40] = 16'h1234;
        rst = 1'b1;
        set_idle_inputs();
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
